// File: rtl/hvsync_pkg.sv
// -----------------------------------------------------------------------------
// hvsync_pkg
// Shared 640x480 video timing constants (also used by hvsync_generator), the
// derived line/frame limits, and the state encoding of the receiver's lock FSM.
// No ports.
// -----------------------------------------------------------------------------
package hvsync_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_BOTTOM  = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_TOP     = 33;

    localparam int VGA_H_MAX        = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK - 1;
    localparam int VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int VGA_V_MAX        = VGA_V_DISPLAY + VGA_V_BOTTOM + VGA_V_SYNC + VGA_V_TOP - 1;
    localparam int VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_BOTTOM;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_H_TRACK = 2'd1;
    localparam logic [1:0] ST_V_TRACK = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    // Cycles per line (or lines per frame) for one timing axis.
    function automatic int timing_total(input int display, input int front,
                                        input int sync, input int back);
        return display + front + sync + back;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Normalises one incoming sync line to active-high, keeps the previous sample
// and flags the leading edge (active now, inactive on the previous sample).
//
// Ports:
//   clk        pixel clock
//   reset      asynchronous active-high reset (previous sample -> inactive)
//   sync_in    raw sync input, polarity set by ACTIVE_LOW
//   lead_edge  combinational leading-edge pulse, valid for the current cycle
// -----------------------------------------------------------------------------
module sync_edge_det
    import hvsync_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic lead_edge
);

    logic sync_act;
    logic sync_prev;

    assign sync_act = ACTIVE_LOW ? ~sync_in : sync_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_prev <= 1'b0;
        end else begin
            sync_prev <= sync_act;
        end
    end

    assign lead_edge = sync_act & ~sync_prev;

endmodule

// File: rtl/hvsync_receiver.sv
// -----------------------------------------------------------------------------
// hvsync_receiver
// Rebuilds hpos/vpos/display_on from an incoming hsync/vsync/rgb stream, checks
// line and frame lengths against the configured timing and reports lock.
//
// Ports:
//   clk         pixel clock
//   reset       asynchronous active-high reset
//   hsync_in    incoming horizontal sync (polarity per SYNC_ACTIVE_LOW)
//   vsync_in    incoming vertical sync (polarity per SYNC_ACTIVE_LOW)
//   rgb_in      incoming pixel {b,g,r}
//   hpos        recovered horizontal position
//   vpos        recovered vertical position
//   display_on  recovered visible-area flag, only while locked
//   rgb_out     rgb_in registered, zero outside display_on
//   locked      timing lock achieved
//   sync_err    one-cycle pulse when an established lock is lost
//   h_total     (HVRX_MEASURE_EN) length of the last completed line
//   v_total     (HVRX_MEASURE_EN) line count of the last completed frame
//
// Build option: define HVRX_MEASURE_EN to add the h_total/v_total measurement.
//
// Lock FSM:
//   state      | meaning
//   IDLE       | no timing reference, waiting for any hsync edge
//   H_TRACK    | counting consecutive correct-length lines
//   V_TRACK    | lines good, waiting for two vsync edges to check one frame
//   LOCKED     | line and frame timing confirmed, picture output enabled
// -----------------------------------------------------------------------------
module hvsync_receiver
    import hvsync_pkg::*;
#(
    parameter int H_DISPLAY       = VGA_H_DISPLAY,
    parameter int H_FRONT         = VGA_H_FRONT,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BACK          = VGA_H_BACK,
    parameter int V_DISPLAY       = VGA_V_DISPLAY,
    parameter int V_BOTTOM        = VGA_V_BOTTOM,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_TOP           = VGA_V_TOP,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int LOCK_LINES      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [2:0]  rgb_in,
    output logic [9:0]  hpos,
    output logic [9:0]  vpos,
    output logic        display_on,
    output logic [2:0]  rgb_out,
    output logic        locked,
`ifdef HVRX_MEASURE_EN
    output logic [10:0] h_total,
    output logic [9:0]  v_total,
`endif
    output logic        sync_err
);

    localparam int H_TOTAL = timing_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = timing_total(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);

    localparam logic [9:0]  H_MAX_C        = 10'(H_TOTAL - 1);
    localparam logic [9:0]  H_SYNC_START_C = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]  H_DISPLAY_C    = 10'(H_DISPLAY);
    localparam logic [9:0]  V_MAX_C        = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_SYNC_START_C = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0]  V_DISPLAY_C    = 10'(V_DISPLAY);
    localparam logic [10:0] LINE_GOOD_LEN  = 11'(H_TOTAL);
    localparam logic [10:0] LINE_TIMEOUT   = 11'(2 * H_TOTAL);
    localparam logic [10:0] LINE_LEN_SAT   = 11'h7FF;
    localparam logic [9:0]  FRAME_GOOD_LEN = 10'(V_TOTAL);
    localparam logic [9:0]  FRAME_SAT      = 10'h3FF;
    localparam int          GOOD_W         = $clog2(LOCK_LINES + 1);
    localparam logic [GOOD_W-1:0] LOCK_LINES_C = GOOD_W'(LOCK_LINES);

    logic hedge;
    logic vedge;

    sync_edge_det #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hsync_edge (
        .clk       (clk),
        .reset     (reset),
        .sync_in   (hsync_in),
        .lead_edge (hedge)
    );

    sync_edge_det #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vsync_edge (
        .clk       (clk),
        .reset     (reset),
        .sync_in   (vsync_in),
        .lead_edge (vedge)
    );

    logic [1:0]        state, state_next;
    logic [GOOD_W-1:0] good_cnt, good_next;
    logic              armed, armed_next;
    logic              err_next;
    logic [9:0]        hpos_next, vpos_next;
    logic [10:0]       line_len, line_len_next;
    logic [9:0]        frame_lines, frame_lines_next;
    logic              line_good, frame_good, timeout;
    logic              lock_next, disp_next;

    // Checks look at the counts accumulated up to (not including) this edge.
    assign line_good  = (line_len == LINE_GOOD_LEN);
    assign frame_good = (frame_lines == FRAME_GOOD_LEN);
    assign timeout    = !hedge && (line_len >= LINE_TIMEOUT);

    always_comb begin
        hpos_next = hpos;
        if (hedge) begin
            hpos_next = H_SYNC_START_C;
        end else if (hpos == H_MAX_C) begin
            hpos_next = '0;
        end else begin
            hpos_next = hpos + 10'd1;
        end

        vpos_next = vpos;
        if (vedge) begin
            vpos_next = V_SYNC_START_C;
        end else if (!hedge && (hpos == H_MAX_C)) begin
            vpos_next = (vpos == V_MAX_C) ? 10'd0 : vpos + 10'd1;
        end

        line_len_next = line_len;
        if (hedge) begin
            line_len_next = 11'd1;
        end else if (line_len != LINE_LEN_SAT) begin
            line_len_next = line_len + 11'd1;
        end

        // An hsync edge coinciding with a vsync edge opens the new frame.
        frame_lines_next = frame_lines;
        if (vedge) begin
            frame_lines_next = hedge ? 10'd1 : 10'd0;
        end else if (hedge && (frame_lines != FRAME_SAT)) begin
            frame_lines_next = frame_lines + 10'd1;
        end
    end

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        armed_next = armed;
        err_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hedge) begin
                    state_next = ST_H_TRACK;
                    good_next  = '0;
                end
            end
            ST_H_TRACK: begin
                if (timeout) begin
                    state_next = ST_IDLE;
                end else if (hedge) begin
                    if (!line_good) begin
                        good_next = '0;
                    end else if (good_cnt + GOOD_W'(1) == LOCK_LINES_C) begin
                        state_next = ST_V_TRACK;
                        armed_next = 1'b0;
                    end else begin
                        good_next = good_cnt + GOOD_W'(1);
                    end
                end
            end
            ST_V_TRACK: begin
                if (timeout) begin
                    state_next = ST_IDLE;
                end else if (hedge && !line_good) begin
                    state_next = ST_H_TRACK;
                    good_next  = '0;
                end else if (vedge) begin
                    if (!armed) begin
                        armed_next = 1'b1;
                    end else if (frame_good) begin
                        state_next = ST_LOCKED;
                    end else begin
                        state_next = ST_H_TRACK;
                        good_next  = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (timeout || (hedge && !line_good) || (vedge && !frame_good)) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Flags are computed from next-state values so they line up with hpos/vpos.
    assign lock_next = (state_next == ST_LOCKED);
    assign disp_next = lock_next && (hpos_next < H_DISPLAY_C) && (vpos_next < V_DISPLAY_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            good_cnt    <= '0;
            armed       <= 1'b0;
            hpos        <= '0;
            vpos        <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            display_on  <= 1'b0;
            rgb_out     <= '0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_next;
            good_cnt    <= good_next;
            armed       <= armed_next;
            hpos        <= hpos_next;
            vpos        <= vpos_next;
            line_len    <= line_len_next;
            frame_lines <= frame_lines_next;
            display_on  <= disp_next;
            rgb_out     <= disp_next ? rgb_in : 3'd0;
            locked      <= lock_next;
            sync_err    <= err_next;
        end
    end

`ifdef HVRX_MEASURE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_total <= '0;
            v_total <= '0;
        end else begin
            if (hedge) begin
                h_total <= line_len;
            end
            if (vedge) begin
                v_total <= frame_lines;
            end
        end
    end
`endif

endmodule
